// File: rtl/sparse_dual_mac_engine.sv
// sparse_dual_mac_engine: walks a range of packed pair-words in the sparse
// weight store, gathers both activations per pair through a dual-port buffer
// and multiply-accumulates the two signed products into one dot product.
// Optional build macro SPARSE_MAC_SAT_EN: saturating accumulator plus a
// sticky sat_flag output; undefined means two's-complement wrap.
module sparse_dual_mac_engine #(
    parameter int DEPTH_PAIRS = 512,
    parameter int INDEX_WIDTH = 12,
    parameter int VALUE_WIDTH = 8,
    parameter int ACT_WIDTH   = 8,
    parameter int ACT_DEPTH   = 4096,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [$clog2(DEPTH_PAIRS)-1:0]   base_addr,
    input  logic [$clog2(DEPTH_PAIRS):0]     num_pairs,
    output logic                             wt_en,
    output logic [$clog2(DEPTH_PAIRS)-1:0]   wt_addr,
    input  logic [INDEX_WIDTH-1:0]           idx0_in,
    input  logic [INDEX_WIDTH-1:0]           idx1_in,
    input  logic [VALUE_WIDTH-1:0]           val0_in,
    input  logic [VALUE_WIDTH-1:0]           val1_in,
    output logic                             act_en0,
    output logic                             act_en1,
    output logic [INDEX_WIDTH-1:0]           act_addr0,
    output logic [INDEX_WIDTH-1:0]           act_addr1,
    input  logic [ACT_WIDTH-1:0]             act_data0,
    input  logic [ACT_WIDTH-1:0]             act_data1,
    output logic                             busy,
    output logic                             result_valid,
    output logic [ACC_WIDTH-1:0]             result,
    output logic                             idx_err
`ifdef SPARSE_MAC_SAT_EN
    ,
    output logic                             sat_flag
`endif
);

    localparam int AW  = $clog2(DEPTH_PAIRS);
    localparam int PW  = VALUE_WIDTH + ACT_WIDTH;
    localparam int AXW = ACC_WIDTH + 2;
    localparam logic [INDEX_WIDTH:0] ACT_LIM = (INDEX_WIDTH + 1)'(ACT_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_PAIRS - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t                       state_r, state_s;
    logic                         wt_en_r;
    logic [AW-1:0]                wt_addr_r;
    logic [AW:0]                  k_r, num_r;
    logic                         drain_r;
    logic                         s1_valid_r, s2_valid_r;
    logic signed [VALUE_WIDTH-1:0] v0_r, v1_r;
    logic                         en0_r, en1_r;
    logic signed [ACC_WIDTH-1:0]  acc_r, acc_next_s, sat_val_s;
    logic [ACC_WIDTH-1:0]         result_r;
    logic                         rv_r, busy_r, idx_err_r, sat_r, clamp_s;
    logic                         nz0_s, nz1_s, inr0_s, inr1_s, act_en0_s, act_en1_s;
    logic                         oor0_s, oor1_s, accept_s, emit_s;
    logic signed [PW-1:0]         prod0_s, prod1_s, p0_s, p1_s;
    logic signed [AXW-1:0]        sum_s;

    // Stage c+1: store data is valid, decide per-lane gathers
    assign nz0_s     = s1_valid_r && (val0_in != {VALUE_WIDTH{1'b0}});
    assign nz1_s     = s1_valid_r && (val1_in != {VALUE_WIDTH{1'b0}});
    assign inr0_s    = {1'b0, idx0_in} < ACT_LIM;
    assign inr1_s    = {1'b0, idx1_in} < ACT_LIM;
    assign act_en0_s = nz0_s && inr0_s;
    assign act_en1_s = nz1_s && inr1_s;
    assign oor0_s    = nz0_s && !inr0_s;
    assign oor1_s    = nz1_s && !inr1_s;

    assign act_en0   = act_en0_s;
    assign act_en1   = act_en1_s;
    assign act_addr0 = s1_valid_r ? idx0_in : {INDEX_WIDTH{1'b0}};
    assign act_addr1 = s1_valid_r ? idx1_in : {INDEX_WIDTH{1'b0}};

    // Stage c+2: signed products of enabled lanes, summed with the accumulator
    assign prod0_s = PW'(v0_r) * PW'($signed(act_data0));
    assign prod1_s = PW'(v1_r) * PW'($signed(act_data1));
    assign p0_s    = en0_r ? prod0_s : {PW{1'b0}};
    assign p1_s    = en1_r ? prod1_s : {PW{1'b0}};
    assign sum_s   = AXW'(acc_r) + AXW'(p0_s) + AXW'(p1_s);

    assign accept_s = (state_r == IDLE) && start;
    assign emit_s   = ((state_r == DRAIN) && drain_r) || ((state_r == DONE) && !rv_r);

`ifdef SPARSE_MAC_SAT_EN
    // Clamp the wide sum into the accumulator range
    always_comb begin
        clamp_s   = 1'b0;
        sat_val_s = sum_s[ACC_WIDTH-1:0];
        if (sum_s > AXW'(ACC_MAX)) begin
            clamp_s   = 1'b1;
            sat_val_s = ACC_MAX;
        end else if (sum_s < AXW'(ACC_MIN)) begin
            clamp_s   = 1'b1;
            sat_val_s = ACC_MIN;
        end else begin
            clamp_s   = 1'b0;
        end
    end
    assign sat_flag = sat_r;
`else
    // Plain two's-complement wrap at the accumulator width
    always_comb begin
        clamp_s   = 1'b0;
        sat_val_s = sum_s[ACC_WIDTH-1:0];
    end
`endif

    assign acc_next_s = s2_valid_r ? sat_val_s : acc_r;

    // Next-state logic for the job sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (num_pairs == {(AW+1){1'b0}}) ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN:     state_s = (k_r == num_r) ? DRAIN : RUN;
            DRAIN:   state_s = drain_r ? DONE : DRAIN;
            DONE:    state_s = rv_r ? IDLE : DONE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Issue counter, read address, job status and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_en_r   <= 1'b0;
            wt_addr_r <= {AW{1'b0}};
            k_r       <= {(AW+1){1'b0}};
            num_r     <= {(AW+1){1'b0}};
            drain_r   <= 1'b0;
            acc_r     <= {ACC_WIDTH{1'b0}};
            result_r  <= {ACC_WIDTH{1'b0}};
            rv_r      <= 1'b0;
            busy_r    <= 1'b0;
            idx_err_r <= 1'b0;
            sat_r     <= 1'b0;
        end else if (accept_s) begin
            num_r     <= num_pairs;
            acc_r     <= {ACC_WIDTH{1'b0}};
            idx_err_r <= 1'b0;
            sat_r     <= 1'b0;
            busy_r    <= 1'b1;
            drain_r   <= 1'b0;
            rv_r      <= 1'b0;
            wt_en_r   <= (num_pairs != {(AW+1){1'b0}});
            wt_addr_r <= base_addr;
            k_r       <= {{AW{1'b0}}, 1'b1};
        end else begin
            acc_r     <= acc_next_s;
            idx_err_r <= idx_err_r | oor0_s | oor1_s;
            sat_r     <= sat_r | (s2_valid_r && clamp_s);
            rv_r      <= emit_s;
            if (emit_s) result_r <= acc_next_s;
            else        result_r <= result_r;
            if ((state_r == DONE) && rv_r) busy_r <= 1'b0;
            else                          busy_r <= busy_r;
            if (state_r == DRAIN) drain_r <= 1'b1;
            else                  drain_r <= 1'b0;
            if ((state_r == RUN) && (k_r != num_r)) begin
                wt_en_r   <= 1'b1;
                wt_addr_r <= (wt_addr_r == LAST_ADDR) ? {AW{1'b0}} : wt_addr_r + {{(AW-1){1'b0}}, 1'b1};
                k_r       <= k_r + {{AW{1'b0}}, 1'b1};
            end else begin
                wt_en_r   <= 1'b0;
            end
        end
    end

    // Pipeline valids and per-lane operands carried into the MAC stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            v0_r       <= {VALUE_WIDTH{1'b0}};
            v1_r       <= {VALUE_WIDTH{1'b0}};
            en0_r      <= 1'b0;
            en1_r      <= 1'b0;
        end else begin
            s1_valid_r <= wt_en_r;
            s2_valid_r <= s1_valid_r;
            v0_r       <= val0_in;
            v1_r       <= val1_in;
            en0_r      <= act_en0_s;
            en1_r      <= act_en1_s;
        end
    end

    assign wt_en        = wt_en_r;
    assign wt_addr      = wt_addr_r;
    assign busy         = busy_r;
    assign result_valid = rv_r;
    assign result       = result_r;
    assign idx_err      = idx_err_r;

endmodule

// File: doc/sparse_dual_mac_engine.md
Name: sparse_dual_mac_engine

Overview:
- Downstream consumer of the dual-entry sparse weight store.
- Per job, walks a contiguous range of packed pair-words and issues one store read per cycle.
- Uses the two returned indices to gather activations from a dual-port activation buffer, then multiply-accumulates both signed products per cycle into one dot-product result.

Parameters:
DEPTH_PAIRS, 512, pair-words in the weight store; sets the wt_addr width to $clog2(DEPTH_PAIRS).
INDEX_WIDTH, 12, weight index width; also the act_addr width.
VALUE_WIDTH, 8, signed weight value width.
ACT_WIDTH, 8, signed activation width.
ACT_DEPTH, 4096, valid activation entries; an index >= ACT_DEPTH is out of range.
ACC_WIDTH, 24, signed accumulator/result width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
base_addr  in  $clog2(DEPTH_PAIRS)  first pair-word of the job
num_pairs  in  $clog2(DEPTH_PAIRS)+1  pair-words in the job (0..DEPTH_PAIRS)
wt_en  out  1  weight store read enable
wt_addr  out  $clog2(DEPTH_PAIRS)  weight store address
idx0_in, idx1_in  in  INDEX_WIDTH  store outputs; valid one cycle after wt_en
val0_in, val1_in  in  VALUE_WIDTH  store outputs, signed
act_en0, act_en1  out  1  activation port read enables
act_addr0, act_addr1  out  INDEX_WIDTH  activation addresses
act_data0, act_data1  in  ACT_WIDTH  signed; valid one cycle after act_en
busy  out  1  high from start acceptance through the result_valid cycle
result_valid  out  1  one-cycle pulse
result  out  ACC_WIDTH  signed dot product; held until next start
idx_err  out  1  sticky: out-of-range index seen in the current job

Behaviour:
- Reset (async, rst_n=0): state IDLE; all of the following are 0 and the pipeline valids are cleared:
  - wt_en, wt_addr, act_en0/1, act_addr0/1
  - busy, result_valid, result, idx_err, accumulator
- Reset mid-job aborts the job immediately; no result is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr/num_pairs, clears the accumulator and idx_err, and sets busy.
  - num_pairs=0 goes to DONE; otherwise goes to RUN.
- RUN:
  - Read counter k counts 0..num_pairs-1.
  - wt_en=1, wt_addr=(base_addr+k) mod DEPTH_PAIRS; the address wraps to 0 past DEPTH_PAIRS-1.
  - After the last issue, go to DRAIN.
- DRAIN: wait 2 cycles for the pipeline to empty, then go to DONE.
- DONE: result_valid=1 and result=accumulator for one cycle, then go to IDLE with busy=0.
- start in any state other than IDLE is ignored.
- Pipeline, per pair issued in cycle c:
  - Cycle c+1:
    - Store data is valid; act_addrN=idxN_in (combinational).
    - act_enN=1 only if valN_in != 0 and idxN_in < ACT_DEPTH.
    - valN and the lane-enable flags are registered.
  - Cycle c+2: act_data is valid; at the end of the cycle, acc += p0 + p1.
    - pN = valN*act_dataN (signed, VALUE_WIDTH+ACT_WIDTH bits) if lane N is enabled, else 0.
    - Products are sign-extended to ACC_WIDTH before the add.
- Latency: start sampled at the end of cycle T gives wt_en in cycles T+1..T+N and result_valid in cycle T+N+3.
  - N=0: result_valid in T+2 with result=0.
- Zero-valued entries (padding) are fetched but contribute 0 and do not assert act_en.
- Out-of-range index with nonzero value:
  - That lane contributes 0.
  - idx_err is set in the cycle after detection and holds until the next start.
  - The other lane of the pair is unaffected.
- Both lanes may address the same activation entry in the same cycle; both reads are legal.
- Overflow with the macro undefined: two's-complement wrap at ACC_WIDTH.

Optional Feature:
- Macro: SPARSE_MAC_SAT_EN.
- Defined:
  - The accumulator saturates to +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1).
  - Extra output port sat_flag (1 bit): sticky per job, reset 0, cleared on start, set when any accumulate clamps.
- Undefined: wrap arithmetic; no sat_flag port.

Test Plan:
- Basic job: base_addr=0, num_pairs=3 with words (idx,val) = {(0,1),(1,2)}, {(2,3),(3,4)}, {(4,-1),(5,0)}; act[i]=i+1 -> wt_addr 0,1,2 in T+1..T+3; result_valid in T+6; result=1+4+9+16-5=25; act_en1=0 for the third pair.
- Wrap: DEPTH_PAIRS=512, base_addr=510, num_pairs=4 -> wt_addr sequence 510,511,0,1; result matches the software dot product.
- Empty job: num_pairs=0 -> no wt_en; result_valid in T+2 with result=0; busy high in T+1..T+2 only.
- Out-of-range index: ACT_DEPTH=16, pair {(20,5),(3,2)}, act[3]=7 -> result=14; idx_err=1 until the next start; act_en0 never asserted for index 20.
- Overflow: ACC_WIDTH=16, 4 pairs of (val=127, act=127) on both lanes (sum 129032).
  - Macro undefined -> result = 129032 mod 2^16 as signed = -2040.
  - SPARSE_MAC_SAT_EN defined -> result=32767, sat_flag=1.
- Reset and busy start: rst_n low in the second RUN cycle -> all outputs 0 immediately, no result_valid; a new start after release runs normally. start pulsed while busy -> ignored, wt_addr sequence unchanged.
